irq_polling_slave_mc: RTL and testbench
=======================================

Name: irq_polling_slave_mc

Overview:
Multi-channel successor to the single-bit interrupt-to-polling register. It synchronises NUM_IRQ asynchronous interrupt inputs into the slave clock domain and captures each one as a sticky pending bit, using either edge or level mode per channel. It exposes pending, mask, mode and raw state through a small memory-mapped slave with fixed read latency, and drives one aggregated, masked interrupt output. It sits between kernel/DMA interrupt sources and the host-visible CSR interconnect, so software can either poll the block or take the aggregated interrupt.

Parameters:
NUM_IRQ, 8, number of interrupt channels, legal range 1..DATA_WIDTH
DATA_WIDTH, 32, slave data width
SYNC_STAGES, 2, synchroniser depth per channel, legal minimum 2
RESET_MODE, all ones (NUM_IRQ bits), reset value of MODE register; 1 selects edge mode, 0 selects level mode

Ports:
clk  input  1  single clock for all logic
reset  input  1  asynchronous, active-high reset
address  input  2  word address: 0 PENDING, 1 MASK, 2 MODE, 3 RAW
read  input  1  read strobe, single cycle
readdata  output  DATA_WIDTH  read data, valid when readdatavalid is high
readdatavalid  output  1  asserted exactly 1 cycle after an accepted read
write  input  1  write strobe, single cycle
writedata  input  DATA_WIDTH  write data
interrupt  input  NUM_IRQ  asynchronous interrupt sources
irq  output  1  registered OR of (pending AND mask)

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock. On reset: all synchroniser flops 0, edge-history register 0, pending 0, mask 0, mode = RESET_MODE, readdata 0, readdatavalid 0, irq 0.
- Synchronisation: each channel passes through a SYNC_STAGES flop chain and the last stage is sync[i]. The chain carries a false-path/synchroniser attribute on its first stage only. Latency from an input change to sync is SYNC_STAGES cycles.
- Edge history: prev[i] <= sync[i] on every cycle.
- Set conditions, per channel:
  - Edge mode (mode[i]=1): set when sync[i] & ~prev[i].
  - Level mode (mode[i]=0): set on every cycle where sync[i] is 1.
  - If an input is already high when reset deasserts, it produces one rising edge on sync and sets pending in edge mode.
- Clear: a write to address 0 clears pending[i] wherever writedata[i]=1 (W1C).
  - If set and clear hit the same bit in the same cycle, set wins.
  - In level mode, a bit whose input is still high therefore stays set.
- Mask does not gate capture. Pending bits accumulate while masked.
- MASK and MODE are read/write; writedata bits at or above NUM_IRQ are ignored.
  - Changing mode does not alter existing pending bits.
  - A switch to edge mode does not generate an edge.
- RAW (address 3) is read-only; it returns sync. Writes to address 3 are ignored.
- Reads:
  - A read samples the selected register in the cycle read is high. readdata and readdatavalid are registered, so data appears 1 cycle later.
  - Bits DATA_WIDTH-1..NUM_IRQ read as 0.
  - readdata holds its last value when readdatavalid is 0.
  - Back-to-back reads are supported, one per cycle.
- Simultaneous read and write:
  - The read returns the pre-write value of the target register.
  - A PENDING read in the same cycle as a W1C returns the pre-clear bits.
- irq <= |(pending & mask). Latency:
  - Input edge to irq: SYNC_STAGES+2 cycles (synchroniser, pending register, irq register).
  - W1C write to irq drop: 2 cycles.
  - Mask write to irq change: 2 cycles.
- No waitrequest; every access is accepted.
- Reset asserted mid-operation clears state immediately, including a pending readdatavalid.

Test Plan:
- Reset defaults: release reset with interrupt=0, read addresses 0..3 -> readdata 0x0, 0x0, 0xFF, 0x0; each readdatavalid exactly 1 cycle after read; irq=0.
- Edge capture and W1C: pulse interrupt[3] for 1 cycle, wait 5 cycles, read PENDING -> 0x08; write 0x08 to address 0, read PENDING -> 0x00; a second pulse sets it again.
- Level mode with set-wins: write MODE=0xFE, hold interrupt[0]=1, W1C 0x01 -> PENDING still 0x01; drop the input, W1C 0x01 -> PENDING 0x00.
- Mask and irq latency: set MASK=0x00, pulse interrupt[5] -> irq stays 0 while PENDING=0x20; write MASK=0x20 -> irq=1 exactly 2 cycles after the write; W1C 0x20 -> irq=0 exactly 2 cycles later.
- Simultaneous read+W1C, and back-to-back reads: with PENDING=0x81, read address 0 while writing 0x80 -> readdata 0x81, next read 0x01; reads on 4 consecutive cycles -> 4 consecutive readdatavalid.
- Reset mid-operation: with PENDING=0xFF, MASK=0xFF, irq=1, assert reset asynchronously between clock edges -> irq, pending and readdatavalid go to 0 immediately; MODE returns to 0xFF.

Source files
------------

// File: rtl/irq_polling_slave_mc_if.sv
// irq_polling_slave_mc_if: CSR slave bus (word address, read/write strobes, registered read data)
interface irq_polling_slave_mc_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            address;
    logic                  read;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/irq_polling_slave_mc.sv
// irq_polling_slave_mc: synchronised sticky interrupt capture with CSR polling and an aggregated masked irq
module irq_polling_slave_mc #(
    parameter int                 NUM_IRQ     = 8,
    parameter int                 DATA_WIDTH  = 32,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] RESET_MODE  = '1
) (
    input  logic                   clk,
    input  logic                   reset,
    irq_polling_slave_mc_if.slave  bus,
    input  logic [NUM_IRQ-1:0]     interrupt,
    output logic                   irq
);
    (* async_reg = "true" *) logic [NUM_IRQ-1:0] r_meta;
    logic [SYNC_STAGES-2:0][NUM_IRQ-1:0] r_chain;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_wdata;
    logic [NUM_IRQ-1:0] w_rd;
    logic               w_unused;

    assign w_sync   = r_chain[SYNC_STAGES-2];
    assign w_wdata  = bus.writedata[NUM_IRQ-1:0];
    assign w_unused = ^bus.writedata;
    // edge mode needs a fresh rising edge, level mode re-asserts every cycle the input is high
    assign w_set    = w_sync & (~r_mode | ~r_prev);
    assign w_clr    = (bus.write && bus.address == 2'd0) ? w_wdata : '0;

    always_comb begin
        w_rd = bus.address == 2'd0 ? r_pending :
               bus.address == 2'd1 ? r_mask :
               bus.address == 2'd2 ? r_mode : w_sync;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta            <= '0;
            r_chain           <= '0;
            r_prev            <= '0;
            r_pending         <= '0;
            r_mask            <= '0;
            r_mode            <= RESET_MODE;
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            r_meta     <= interrupt;
            r_chain[0] <= r_meta;
            for (int k = 1; k < SYNC_STAGES - 1; k++)
                r_chain[k] <= r_chain[k-1];
            r_prev    <= w_sync;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (bus.write && bus.address == 2'd1)
                r_mask <= w_wdata;
            if (bus.write && bus.address == 2'd2)
                r_mode <= w_wdata;
            if (bus.read)
                bus.readdata <= DATA_WIDTH'(w_rd);
            bus.readdatavalid <= bus.read;
            irq               <= |(r_pending & r_mask);
        end
    end
endmodule

// File: tb/tb_irq_polling_slave_mc.sv
// tb_irq_polling_slave_mc: table-driven CSR sequences with a read-data scoreboard plus irq/reset corner cases
module tb_irq_polling_slave_mc;
    typedef enum logic [2:0] {OP_WR, OP_RD, OP_PULSE, OP_HOLD, OP_IDLE} op_e;
    typedef struct {
        op_e         kind;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } op_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] interrupt = '0;
    logic       irq;
    logic       rd_at_edge = 1'b0;
    logic [31:0] q[$];
    op_t        tbl[$];
    int         vectors = 0;
    int         fails = 0;
    int         rdv_cnt = 0;

    irq_polling_slave_mc_if #(.DATA_WIDTH(32)) bus ();

    irq_polling_slave_mc dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .interrupt (interrupt),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_at_edge = reset ? 1'b0 : bus.read;

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_at_edge || bus.readdatavalid)
                check("readdatavalid", 32'(bus.readdatavalid), 32'(rd_at_edge));
            if (bus.readdatavalid) begin
                rdv_cnt++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL readdata: unexpected data 0x%0h, none expected", bus.readdata);
                end else begin
                    check("readdata", bus.readdata, q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
        bus.write = 1'b1; bus.address = a; bus.writedata = d;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic do_rd(input logic [1:0] a, input logic [31:0] exp);
        bus.read = 1'b1; bus.address = a;
        q.push_back(exp);
        tick();
        bus.read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        check("irq_after_reset", 32'(irq), 32'h0);
        check("rdv_after_reset", 32'(bus.readdatavalid), 32'h0);

        tbl.push_back('{OP_RD, 2'd0, 32'h0, 32'h00});
        tbl.push_back('{OP_RD, 2'd1, 32'h0, 32'h00});
        tbl.push_back('{OP_RD, 2'd2, 32'h0, 32'hFF});
        tbl.push_back('{OP_RD, 2'd3, 32'h0, 32'h00});
        tbl.push_back('{OP_PULSE, 2'd0, 32'h08, 32'h0});
        tbl.push_back('{OP_IDLE, 2'd0, 32'd5, 32'h0});
        tbl.push_back('{OP_RD, 2'd0, 32'h0, 32'h08});
        tbl.push_back('{OP_WR, 2'd0, 32'h08, 32'h0});
        tbl.push_back('{OP_RD, 2'd0, 32'h0, 32'h00});
        tbl.push_back('{OP_PULSE, 2'd0, 32'h08, 32'h0});
        tbl.push_back('{OP_IDLE, 2'd0, 32'd5, 32'h0});
        tbl.push_back('{OP_RD, 2'd0, 32'h0, 32'h08});
        tbl.push_back('{OP_WR, 2'd0, 32'h08, 32'h0});
        tbl.push_back('{OP_WR, 2'd2, 32'hFFFF_FFFE, 32'h0});
        tbl.push_back('{OP_RD, 2'd2, 32'h0, 32'hFE});
        tbl.push_back('{OP_HOLD, 2'd0, 32'h01, 32'h0});
        tbl.push_back('{OP_IDLE, 2'd0, 32'd4, 32'h0});
        tbl.push_back('{OP_RD, 2'd3, 32'h0, 32'h01});
        tbl.push_back('{OP_WR, 2'd0, 32'h01, 32'h0});
        tbl.push_back('{OP_RD, 2'd0, 32'h0, 32'h01});
        tbl.push_back('{OP_HOLD, 2'd0, 32'h00, 32'h0});
        tbl.push_back('{OP_IDLE, 2'd0, 32'd4, 32'h0});
        tbl.push_back('{OP_WR, 2'd0, 32'h01, 32'h0});
        tbl.push_back('{OP_RD, 2'd0, 32'h0, 32'h00});
        tbl.push_back('{OP_WR, 2'd3, 32'hFF, 32'h0});
        tbl.push_back('{OP_RD, 2'd3, 32'h0, 32'h00});
        tbl.push_back('{OP_WR, 2'd2, 32'hFF, 32'h0});
        tbl.push_back('{OP_RD, 2'd2, 32'h0, 32'hFF});
        tbl.push_back('{OP_RD, 2'd0, 32'h0, 32'h00});

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                OP_WR:    do_wr(tbl[i].a, tbl[i].d);
                OP_RD:    do_rd(tbl[i].a, tbl[i].exp);
                OP_PULSE: begin interrupt = tbl[i].d[7:0]; tick(); interrupt = '0; end
                OP_HOLD:  interrupt = tbl[i].d[7:0];
                default:  idle(int'(tbl[i].d));
            endcase
        end
        idle(2);

        // masked capture, then mask/W1C to irq latency of exactly 2 cycles
        do_wr(2'd1, 32'h00);
        interrupt = 8'h20; tick(); interrupt = '0;
        idle(5);
        check("irq_masked", 32'(irq), 32'h0);
        do_rd(2'd0, 32'h20);
        idle(1);
        bus.write = 1'b1; bus.address = 2'd1; bus.writedata = 32'h20;
        tick();
        bus.write = 1'b0;
        check("irq_mask_1cyc", 32'(irq), 32'h0);
        tick();
        check("irq_mask_2cyc", 32'(irq), 32'h1);
        bus.write = 1'b1; bus.address = 2'd0; bus.writedata = 32'h20;
        tick();
        bus.write = 1'b0;
        check("irq_w1c_1cyc", 32'(irq), 32'h1);
        tick();
        check("irq_w1c_2cyc", 32'(irq), 32'h0);

        // read and W1C in the same cycle return the pre-clear bits
        interrupt = 8'h81; tick(); interrupt = '0;
        idle(5);
        bus.read = 1'b1; bus.write = 1'b1; bus.address = 2'd0; bus.writedata = 32'h80;
        q.push_back(32'h81);
        tick();
        bus.read = 1'b0; bus.write = 1'b0;
        do_rd(2'd0, 32'h01);
        do_wr(2'd0, 32'h01);
        idle(2);

        rdv_cnt = 0;
        do_rd(2'd0, 32'h00);
        do_rd(2'd1, 32'h20);
        do_rd(2'd2, 32'hFF);
        do_rd(2'd3, 32'h00);
        idle(2);
        check("back_to_back_rdv", 32'(rdv_cnt), 32'd4);

        // asynchronous reset between edges with a read in flight
        do_wr(2'd1, 32'hFF);
        do_wr(2'd2, 32'h0F);
        interrupt = 8'hFF; tick(); interrupt = '0;
        idle(5);
        check("irq_all_pending", 32'(irq), 32'h1);
        bus.read = 1'b1; bus.address = 2'd0;
        @(posedge clk);
        #2;
        bus.read = 1'b0;
        reset = 1'b1;
        #1;
        check("irq_async_reset", 32'(irq), 32'h0);
        check("rdv_async_reset", 32'(bus.readdatavalid), 32'h0);
        check("readdata_async_reset", bus.readdata, 32'h0);
        q.delete();
        idle(2);
        #2 reset = 1'b0;
        tick();
        do_rd(2'd0, 32'h00);
        do_rd(2'd1, 32'h00);
        do_rd(2'd2, 32'hFF);
        idle(3);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
